// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin arbiter that shares one SPI master engine between NREQ requesters.
// Optional build macro SPI_ARB_TIMEOUT_EN bounds WAIT to TIMEOUT cycles and answers with rsp_err=1.
module spi_txn_arbiter #(
    parameter int NREQ         = 4,
    parameter int DWIDTH       = 32,
    parameter int NSLAVES      = 4,
    parameter int S_ADDR_WIDTH = $clog2(NSLAVES),
    parameter int GID_WIDTH    = $clog2(NREQ),
    parameter int TIMEOUT      = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ*S_ADDR_WIDTH-1:0] req_slave,
    input  logic [NREQ*DWIDTH-1:0]       req_wdata,
    output logic [NREQ-1:0]              req_ready,
    output logic [NREQ-1:0]              rsp_valid,
    output logic [DWIDTH-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic                         m_start,
    output logic [S_ADDR_WIDTH-1:0]      m_slave,
    output logic [DWIDTH-1:0]            m_wdata,
    input  logic                         m_busy,
    input  logic                         m_done,
    input  logic [DWIDTH-1:0]            m_rdata,
    output logic [GID_WIDTH-1:0]         grant_id,
    output logic                         busy
);
    typedef enum logic [1:0] {IDLE, START, WAIT} state_e;
    state_e                  state_q, state_d;
    logic [GID_WIDTH-1:0]    ptr_q, ptr_d, gid_q, gid_d, win, idx;
    logic                    found;
    logic [S_ADDR_WIDTH-1:0] slave_q, slave_d, sel_slave;
    logic [DWIDTH-1:0]       wdata_q, wdata_d, sel_wdata, rdata_q, rdata_d;
    logic [NREQ-1:0]         ready_q, ready_d, rvalid_q, rvalid_d;
    logic                    start_q, start_d, err_q, err_d, busy_q, busy_d;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0]           cnt_q, cnt_d;
`endif

    // Winner is the first active request strictly after the last grant, wrapping modulo NREQ.
    always_comb begin
        win = '0;
        idx = '0;
        found = 1'b0;
        sel_slave = '0;
        sel_wdata = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = GID_WIDTH'((int'(ptr_q) + i) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (win == GID_WIDTH'(i)) begin
                sel_slave = req_slave[i*S_ADDR_WIDTH +: S_ADDR_WIDTH];
                sel_wdata = req_wdata[i*DWIDTH +: DWIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gid_d    = gid_q;
        slave_d  = slave_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = '0;
        err_d    = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: if (!m_busy && found) begin
                state_d = START;
                ptr_d   = win;
                gid_d   = win;
                slave_d = sel_slave;
                wdata_d = sel_wdata;
            end
            START: begin
                state_d = WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
`ifdef SPI_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (m_done) begin
                    state_d  = IDLE;
                    rdata_d  = m_rdata;
                    rvalid_d = NREQ'(1) << gid_q;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d  = IDLE;
                    rdata_d  = '0;
                    err_d    = 1'b1;
                    rvalid_d = NREQ'(1) << gid_q;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        start_d = state_d == START;
        ready_d = start_d ? NREQ'(1) << gid_d : '0;
        busy_d  = state_d != IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= GID_WIDTH'(NREQ - 1);
            gid_q    <= '0;
            slave_q  <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= '0;
            ready_q  <= '0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gid_q    <= gid_d;
            slave_q  <= slave_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ready_q  <= ready_d;
            start_q  <= start_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rvalid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign m_start   = start_q;
    assign m_slave   = slave_q;
    assign m_wdata   = wdata_q;
    assign grant_id  = gid_q;
    assign busy      = busy_q;
endmodule
